issue_stage_sb: RTL
===================

Name: issue_stage_sb

Overview:
- Next-generation decode/register-read stage: sits between the Decoder and the ALU/MUL units, after decode and before execute.
- Holds the architectural register file (2 read, 1 write) and a per-register scoreboard of in-flight writers.
- Forwards operands from NUM_BYPASS parametrised bypass buses.
- Registers a single issue slot with valid/ready handshakes per execution unit.
- Stalls on RAW/WAW hazards that no bypass can resolve.

Parameters:
- REG_ADDRESS_SIZE, 5, register index width; register count = 2**REG_ADDRESS_SIZE.
- REG_SIZE, 32, register/operand width.
- ADDRESS_SIZE, 32, PC width.
- NUM_BYPASS, 2, number of bypass buses; index 0 = youngest producer.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  ADDRESS_SIZE  instruction PC.
- in_addr_r1, in_addr_r2  in  REG_ADDRESS_SIZE  source register indices.
- in_Ie  in  1  operand2 comes from in_immediate.
- in_immediate  in  REG_SIZE  immediate value.
- in_dest  in  REG_ADDRESS_SIZE  destination register.
- in_we  in  1  instruction writes in_dest.
- in_is_alu, in_is_mul  in  1  target unit; exactly one is set when in_valid.
- byp_valid  in  NUM_BYPASS  bypass bus i carries a result.
- byp_addr  in  NUM_BYPASS*REG_ADDRESS_SIZE  packed bypass destinations.
- byp_value  in  NUM_BYPASS*REG_SIZE  packed bypass values.
- wb_we, wb_addr, wb_value  in  1/REG_ADDRESS_SIZE/REG_SIZE  writeback port.
- flush  in  1  kill the instruction held in the issue slot.
- out_valid  out  1  issue slot full.
- out_pc, out_operand1, out_operand2, out_dest, out_we, out_use_alu, out_use_mul  out  as inputs  issue slot contents.
- alu_ready, mul_ready  in  1  unit accepts this cycle.
- stall  out  1  = in_valid && !in_ready.

Behaviour:
- Reset, asynchronous on reset=0:
  - out_valid=0; all other out_* = 0.
  - Scoreboard pending[] all 0.
  - Register file all 0.
- out_fire = out_valid && ((out_use_alu && alu_ready) || (out_use_mul && mul_ready)).
- Register file:
  - Write on wb_we at the clock edge.
  - Reads are combinational with write-through: if wb_we && wb_addr==ra, the read returns wb_value.
- Operand resolution for source ra, in priority order:
  1. Lowest i with byp_valid[i] && byp_addr[i]==ra: byp_value[i].
  2. wb_we && wb_addr==ra: wb_value.
  3. Otherwise the register file.
- Resolved: a source is resolved if it matches a bypass or writeback this cycle, or if it is not busy.
- busy(r) = pending[r] || (out_valid && out_we && out_dest==r && !out_fire).
- Hazard = RAW on r1, OR RAW on r2 when !in_Ie, OR (in_we && busy(in_dest)).
  - WAW hazards stall; the scoreboard never holds two writers of one register.
  - The bypass/writeback resolution does not clear a WAW hazard.
- in_ready = !hazard && (!out_valid || out_fire) && !flush.
- Issue slot latency: 1 cycle. An accepted instruction appears on out_* the next cycle.
  - out_operand2 = in_immediate when in_Ie.
  - Slot holds its value stable while out_valid && !out_fire.
- Scoreboard:
  - On out_fire && out_we: set pending[out_dest].
  - On wb_we: clear pending[wb_addr].
  - Same register set and cleared in the same cycle: set wins.
- Flush:
  - Clears out_valid next cycle and blocks acceptance that cycle.
  - The scoreboard is untouched; a killed instruction never set a bit.
  - flush and out_fire in the same cycle: the fire completes and the scoreboard is set.
- Bypass/writeback to a register that is not pending: legal, used by priority, no state change.

Optional Feature:
- ZERO_REG_EN defined:
  - Register 0 reads as 0 and is never busy.
  - Writes to it are dropped and the scoreboard bit is never set.
  - Bypasses addressed to 0 are ignored.
- ZERO_REG_EN undefined: register 0 is an ordinary register.

Decomposition:
- Package issue_pkg:
  - Default widths.
  - Issue-bundle struct {pc, op1, op2, dest, we, use_alu, use_mul}.
  - Helper function for bypass priority selection.
- Sub-module issue_scoreboard:
  - pending[] vector, set/clear ports, busy query.
- Register file, bypass mux and issue slot stay in the top.

Test Plan:
- Reset, then wb writes r3=0x11; issue ADD r5=r3+r3 -> one cycle later out_operand1=out_operand2=0x11, out_use_alu=1, no stall.
- Issue r4=... to ALU (fires); next instr reads r4 with byp_valid[0]=1, byp_addr=4, byp_value=0xAA -> operand1=0xAA, stall=0.
- r4 pending; no bypass, no writeback -> stall=1 for each cycle. Then wb_we r4=0x77 -> accepted that cycle, operand1=0x77, pending[4] cleared.
- Bypass 0 and 1 both target r2 (0x1, 0x2) -> operand=0x1. With only wb r2=0x3 -> 0x3.
- out_valid with mul_ready=0 held 3 cycles -> out_* stable, in_ready=0. Then flush -> out_valid=0 next cycle, pending[out_dest] still 0.
- ZERO_REG_EN: wb r0=0x55, then read r0 -> 0. Without ZERO_REG_EN -> 0x55.

Source files
------------

// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared widths, issue-slot bundle and bypass priority helper for issue_stage_sb
package issue_pkg;

    localparam int REG_ADDRESS_SIZE_DEF = 5;
    localparam int REG_SIZE_DEF         = 32;
    localparam int ADDRESS_SIZE_DEF     = 32;
    localparam int NUM_BYPASS_DEF       = 2;
    localparam int MAX_BYPASS           = 8;
    localparam int BYP_SEL_W            = $clog2(MAX_BYPASS) + 1;
    localparam logic [BYP_SEL_W-1:0] BYP_NONE = BYP_SEL_W'(MAX_BYPASS);

    typedef struct packed {
        logic [ADDRESS_SIZE_DEF-1:0]     pc;
        logic [REG_SIZE_DEF-1:0]         op1;
        logic [REG_SIZE_DEF-1:0]         op2;
        logic [REG_ADDRESS_SIZE_DEF-1:0] dest;
        logic                            we;
        logic                            use_alu;
        logic                            use_mul;
    } issue_bundle_t;

    // Bus 0 carries the youngest producer, so the lowest matching index wins.
    function automatic logic [BYP_SEL_W-1:0] byp_select(input logic [MAX_BYPASS-1:0] match);
        logic [BYP_SEL_W-1:0] sel;
        sel = BYP_NONE;
        for (int i = MAX_BYPASS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel = BYP_SEL_W'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - per-register pending-writer bits with set/clear ports and busy query
module issue_scoreboard #(
    parameter int REG_ADDRESS_SIZE = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              set_en,
    input  logic [REG_ADDRESS_SIZE-1:0]       set_addr,
    input  logic                              clr_en,
    input  logic [REG_ADDRESS_SIZE-1:0]       clr_addr,
    input  logic [2:0][REG_ADDRESS_SIZE-1:0]  query_addr,
    output logic [2:0]                        query_pending
);

    localparam int NREG = 1 << REG_ADDRESS_SIZE;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        query_pending = '0;
        for (int q = 0; q < 3; q++) begin
            query_pending[q] = pending_q[query_addr[q]];
        end
    end

endmodule

// File: rtl/issue_stage_sb.sv
// rtl/issue_stage_sb.sv - register read, bypass, scoreboard and issue slot; ZERO_REG_EN hardwires r0
module issue_stage_sb
    import issue_pkg::*;
#(
    parameter int REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEF,
    parameter int REG_SIZE         = REG_SIZE_DEF,
    parameter int ADDRESS_SIZE     = ADDRESS_SIZE_DEF,
    parameter int NUM_BYPASS       = NUM_BYPASS_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ADDRESS_SIZE-1:0]              in_pc,
    input  logic [REG_ADDRESS_SIZE-1:0]          in_addr_r1,
    input  logic [REG_ADDRESS_SIZE-1:0]          in_addr_r2,
    input  logic                                 in_Ie,
    input  logic [REG_SIZE-1:0]                  in_immediate,
    input  logic [REG_ADDRESS_SIZE-1:0]          in_dest,
    input  logic                                 in_we,
    input  logic                                 in_is_alu,
    input  logic                                 in_is_mul,
    input  logic [NUM_BYPASS-1:0]                byp_valid,
    input  logic [NUM_BYPASS*REG_ADDRESS_SIZE-1:0] byp_addr,
    input  logic [NUM_BYPASS*REG_SIZE-1:0]       byp_value,
    input  logic                                 wb_we,
    input  logic [REG_ADDRESS_SIZE-1:0]          wb_addr,
    input  logic [REG_SIZE-1:0]                  wb_value,
    input  logic                                 flush,
    output logic                                 out_valid,
    output logic [ADDRESS_SIZE-1:0]              out_pc,
    output logic [REG_SIZE-1:0]                  out_operand1,
    output logic [REG_SIZE-1:0]                  out_operand2,
    output logic [REG_ADDRESS_SIZE-1:0]          out_dest,
    output logic                                 out_we,
    output logic                                 out_use_alu,
    output logic                                 out_use_mul,
    input  logic                                 alu_ready,
    input  logic                                 mul_ready,
    output logic                                 stall
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam int NREG = 1 << REG_ADDRESS_SIZE;

    logic [REG_SIZE-1:0]         rf_q [NREG];
    logic [REG_SIZE-1:0]         rf_d [NREG];
    issue_bundle_t               slot_q, slot_d;
    logic                        out_valid_q, out_valid_d;

    logic                        out_fire, wb_we_eff, sb_set, slot_busy_en, dest_busy, hazard;
    logic [REG_ADDRESS_SIZE-1:0] src_addr [2];
    logic [REG_SIZE-1:0]         opnd [2];
    logic [1:0]                  src_resolved;
    logic [2:0]                  query_pending;

    assign out_fire     = out_valid_q && ((slot_q.use_alu && alu_ready) || (slot_q.use_mul && mul_ready));
    assign wb_we_eff    = wb_we && !(ZERO_REG && wb_addr == '0);
    assign sb_set       = out_fire && slot_q.we && !(ZERO_REG && slot_q.dest == '0);
    assign slot_busy_en = out_valid_q && slot_q.we && !out_fire;
    assign src_addr[0]  = in_addr_r1;
    assign src_addr[1]  = in_addr_r2;

    issue_scoreboard #(.REG_ADDRESS_SIZE(REG_ADDRESS_SIZE)) u_sb (
        .clk           (clk),
        .reset         (reset),
        .set_en        (sb_set),
        .set_addr      (slot_q.dest),
        .clr_en        (wb_we_eff),
        .clr_addr      (wb_addr),
        .query_addr    ({in_dest, in_addr_r2, in_addr_r1}),
        .query_pending (query_pending)
    );

    // Operand resolution: youngest bypass, then writeback, then register file.
    always_comb begin
        logic [MAX_BYPASS-1:0] match;
        logic [BYP_SEL_W-1:0]  sel;
        logic                  wb_hit;
        logic                  busy;
        opnd[0]      = '0;
        opnd[1]      = '0;
        src_resolved = '0;
        for (int s = 0; s < 2; s++) begin
            match = '0;
            for (int i = 0; i < NUM_BYPASS; i++) begin
                match[i] = byp_valid[i] && (byp_addr[i*REG_ADDRESS_SIZE +: REG_ADDRESS_SIZE] == src_addr[s])
                           && !(ZERO_REG && src_addr[s] == '0);
            end
            sel    = byp_select(match);
            wb_hit = wb_we_eff && (wb_addr == src_addr[s]);
            busy   = !(ZERO_REG && src_addr[s] == '0)
                     && (query_pending[s] || (slot_busy_en && slot_q.dest == src_addr[s]));
            if (sel != BYP_NONE) begin
                opnd[s] = byp_value[int'(sel)*REG_SIZE +: REG_SIZE];
            end else if (wb_hit) begin
                opnd[s] = wb_value;
            end else begin
                opnd[s] = rf_q[src_addr[s]];
            end
            src_resolved[s] = (sel != BYP_NONE) || wb_hit || !busy;
        end
    end

    // A forwarded value never clears a WAW hazard on the destination.
    assign dest_busy = !(ZERO_REG && in_dest == '0)
                       && (query_pending[2] || (slot_busy_en && slot_q.dest == in_dest));
    assign hazard    = !src_resolved[0] || (!in_Ie && !src_resolved[1]) || (in_we && dest_busy);
    assign in_ready  = !hazard && (!out_valid_q || out_fire) && !flush;
    assign stall     = in_valid && !in_ready;

    always_comb begin
        rf_d = rf_q;
        if (wb_we_eff) begin
            rf_d[wb_addr] = wb_value;
        end
    end

    always_comb begin
        slot_d      = slot_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid_d    = 1'b1;
            slot_d.pc      = in_pc;
            slot_d.op1     = opnd[0];
            slot_d.op2     = in_Ie ? in_immediate : opnd[1];
            slot_d.dest    = in_dest;
            slot_d.we      = in_we;
            slot_d.use_alu = in_is_alu;
            slot_d.use_mul = in_is_mul;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            slot_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = slot_q.pc;
    assign out_operand1 = slot_q.op1;
    assign out_operand2 = slot_q.op2;
    assign out_dest     = slot_q.dest;
    assign out_we       = slot_q.we;
    assign out_use_alu  = slot_q.use_alu;
    assign out_use_mul  = slot_q.use_mul;

endmodule
